// File: rtl/riscv_dm_pkg.sv
// Shared DMI/DTM types for the debug transport path.
// Op encodings, dtmcs layout and the DTM controller states.
package riscv_dm_pkg;

  localparam logic [1:0] WR_OP_NOP = 2'd0;
  localparam logic [1:0] WR_OP_RD  = 2'd1;
  localparam logic [1:0] WR_OP_WR  = 2'd2;

  localparam logic [1:0] RD_OP_SUCCESS = 2'd0;
  localparam logic [1:0] RD_OP_FAILED  = 2'd2;
  localparam logic [1:0] RD_OP_BUSY    = 2'd3;

  localparam logic [3:0] DTM_VERSION = 4'd1;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dtmhardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DRAIN
  } dtm_state_e;

  // Width of a {addr,data,op} DMI word.
  function automatic int dmi_width(input int aw,
                                   input int dw);
    return aw + dw + 2;
  endfunction

endpackage

// File: rtl/riscv_dmi_fifo.sv
// Synchronous request FIFO for queued DMI updates.
// Push is ignored when full, pop when empty; flush clears it.
module riscv_dmi_fifo
  import riscv_dm_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    end
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_dtm_dmi_ctrl.sv
// DTM-side DMI transaction controller: queues scan updates,
// issues them to the DM and tracks sticky dmistat.
module riscv_dtm_dmi_ctrl
  import riscv_dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 2,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             upd_valid_i,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] upd_dmi_i,
  input  logic                             cap_i,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] cap_dmi_o,
  input  logic                             dmireset_i,
  input  logic                             dtmhardreset_i,
  output logic [31:0]                      dtmcs_o,
  output logic                             req_valid_o,
  input  logic                             req_ready_i,
  output logic [ADDR_WIDTH-1:0]            req_addr_o,
  output logic [DATA_WIDTH-1:0]            req_data_o,
  output logic [1:0]                       req_op_o,
  input  logic                             rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]            rsp_data_i,
  input  logic                             rsp_err_i
);

  localparam int W = dmi_width(ADDR_WIDTH, DATA_WIDTH);

  dtm_state_e            state_q, state_d;
  logic [1:0]            dmistat_q, dmistat_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic [W-1:0]          cap_q, cap_d;
  logic [1:0]            cur_op_q, cur_op_d;

  logic [ADDR_WIDTH-1:0] upd_addr, h_addr;
  logic [DATA_WIDTH-1:0] upd_data, h_data;
  logic [1:0]            upd_op, h_op;
  logic [W-1:0]          head;
  logic                  full, empty;
  logic                  push, pop;
  logic                  upd_cmd, busy_upd, busy_cap, fail;
  logic                  pending;
  logic [1:0]            stat_eff, cap_status;
  dtmcs_t                dtmcs;

  assign {upd_addr, upd_data, upd_op} = upd_dmi_i;
  assign {h_addr, h_data, h_op} = head;

  riscv_dmi_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (dtmhardreset_i),
    .push_i  (push),
    .data_i  (upd_dmi_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d     = state_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    cur_op_d    = cur_op_q;
    pop         = 1'b0;
    fail        = 1'b0;

    // dmireset lands before this cycle's update and capture
    stat_eff = dmireset_i ? RD_OP_SUCCESS : dmistat_q;
    upd_cmd  = upd_valid_i && !dtmhardreset_i &&
               (stat_eff == RD_OP_SUCCESS) &&
               (upd_op == WR_OP_RD || upd_op == WR_OP_WR);
    push     = upd_cmd && !full;
    busy_upd = upd_cmd && full;
    pending  = !empty || (state_q != IDLE);

    if (stat_eff != RD_OP_SUCCESS) cap_status = stat_eff;
    else if (pending)              cap_status = RD_OP_BUSY;
    else                           cap_status = RD_OP_SUCCESS;
    busy_cap = cap_i && (stat_eff == RD_OP_SUCCESS) && pending;

    if (push) last_addr_d = upd_addr;

    unique case (state_q)
      IDLE: begin
        if (!empty && !dtmhardreset_i) state_d = REQ;
      end
      REQ: begin
        if (dtmhardreset_i) begin
          state_d = IDLE;
        end else if (req_ready_i) begin
          pop      = 1'b1;
          cur_op_d = h_op;
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dtmhardreset_i) begin
          state_d = DRAIN;
        end else if (rsp_valid_i) begin
          if (cur_op_q == WR_OP_RD) last_data_d = rsp_data_i;
          fail    = rsp_err_i && (stat_eff == RD_OP_SUCCESS);
          state_d = empty ? IDLE : REQ;
        end
      end
      DRAIN: begin
        if (rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dmistat_d = stat_eff;
    if (busy_upd || busy_cap) dmistat_d = RD_OP_BUSY;
    if (fail)                 dmistat_d = RD_OP_FAILED;
    if (dtmhardreset_i)       dmistat_d = RD_OP_SUCCESS;

    cap_d = cap_q;
    if (cap_i) cap_d = {last_addr_q, last_data_q, cap_status};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      dmistat_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      cap_q       <= '0;
      cur_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      dmistat_q   <= dmistat_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      cap_q       <= cap_d;
      cur_op_q    <= cur_op_d;
    end
  end

  always_comb begin
    dtmcs         = '0;
    dtmcs.version = DTM_VERSION;
    dtmcs.abits   = 6'(ADDR_WIDTH);
    dtmcs.dmistat = dmistat_q;
    dtmcs.idle    = 3'(IDLE_CYCLES);
  end

  assign dtmcs_o     = dtmcs;
  assign cap_dmi_o   = cap_q;
  assign req_valid_o = (state_q == REQ);
  assign req_addr_o  = h_addr;
  assign req_data_o  = h_data;
  assign req_op_o    = h_op;

endmodule

// File: doc/riscv_dtm_dmi_ctrl.md
Name: riscv_dtm_dmi_ctrl

Overview:
DTM-side DMI transaction controller. It sits between the JTAG DTM shift logic and the Debug Module DMI port. It accepts DMI scan updates and queues them in a parametrised request FIFO. It issues requests to the DM over a valid/ready handshake and returns capture data, tracking sticky dmistat (busy/failed) with dmireset and dtmhardreset. This generalises the fixed single-transaction DMI path to configurable address width, data width and queue depth.

Parameters:
ADDR_WIDTH, 9, DMI address bits; reported in dtmcs.abits.
DATA_WIDTH, 32, DMI data bits.
DEPTH, 2, request FIFO entries; power of two, >=1.
IDLE_CYCLES, 2, value reported in dtmcs.idle.

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
upd_valid_i  in  1  one-cycle pulse: DMI update-DR
upd_dmi_i  in  ADDR_WIDTH+DATA_WIDTH+2  {addr,data,op} scanned in
cap_i  in  1  one-cycle pulse: DMI capture-DR
cap_dmi_o  out  ADDR_WIDTH+DATA_WIDTH+2  {last addr, last rdata, status}
dmireset_i  in  1  pulse: clear sticky dmistat
dtmhardreset_i  in  1  pulse: abort all DMI activity
dtmcs_o  out  32  dtmcs word (version=1, idle, dmistat, abits)
req_valid_o  out  1  request to DM valid
req_ready_i  in  1  DM accepts request
req_addr_o  out  ADDR_WIDTH  request address
req_data_o  out  DATA_WIDTH  write data
req_op_o  out  2  WR_OP_RD / WR_OP_WR
rsp_valid_i  in  1  DM response valid (one cycle)
rsp_data_i  in  DATA_WIDTH  read data
rsp_err_i  in  1  DM reports failure

Behaviour:
- Reset (rstn_i=0 at clk edge): FIFO empty; state IDLE; dmistat=0; last addr/data=0; req_valid_o=0. cap_dmi_o=0. dtmcs_o holds only constants (version=1, idle=IDLE_CYCLES, abits=ADDR_WIDTH).
- Update, evaluated after any same-cycle dmireset:
  - dmistat!=0: drop.
  - op=NOP or op=2'b11: drop, no status change.
  - RD/WR with FIFO full (registered count==DEPTH): drop, dmistat<=3 (busy). A same-cycle pop does not free space.
  - Otherwise push {addr,data,op}; last addr<=addr.
- FSM:
  - IDLE: FIFO non-empty -> REQ.
  - REQ: req_valid_o=1 with FIFO head; fields stable until req_ready_i. On handshake, pop -> WAIT_RSP.
  - WAIT_RSP: on rsp_valid_i, last rdata<=rsp_data_i for reads (writes leave it unchanged). If rsp_err_i and dmistat==0, dmistat<=2. Then -> REQ if FIFO non-empty, else IDLE.
  - DRAIN: entered from WAIT_RSP on dtmhardreset_i; discard the next response; -> IDLE.
- A response arriving in IDLE/REQ is ignored.
- Pending = FIFO non-empty or state!=IDLE.
- Capture, registered on cap_i:
  - status = dmistat if nonzero; else 3 if pending (also sets dmistat<=3); else 0.
  - cap_dmi_o = {last addr, last rdata, status}, held until next cap_i.
- dmireset_i: dmistat<=0. It does not flush the FIFO.
- dtmhardreset_i: flush FIFO, dmistat<=0, req_valid_o<=0 next cycle. REQ -> IDLE; WAIT_RSP -> DRAIN. It has priority over a same-cycle update, which is dropped.
- Busy set by capture and failed set by a response in the same cycle: failed wins.
- dtmcs_o is combinational from the registered dmistat; dmireset/dtmhardreset read as 0.
- Latency: update to req_valid_o is 2 cycles when idle (push, then REQ).

Decomposition:
- Shared package riscv_dm_pkg:
  - dmi_t generalised as a parametrised width helper.
  - WR_OP_*/RD_OP_* constants.
  - dtmcs_t.
  - new dtm_state_e {IDLE,REQ,WAIT_RSP,DRAIN}.
- Sub-module riscv_dmi_fifo: synchronous FIFO, DEPTH entries, push/pop/full/empty/flush, pointer wrap at DEPTH.

Test Plan:
- Reset, then cap_i -> cap_dmi_o=0; dtmcs_o[3:0]=1, [9:4]=9, [14:12]=2, [11:10]=0.
- Update RD addr 0x11; DM readies 1 cycle later and returns 0x00400C82 -> req_valid_o 2 cycles after update; next cap_i gives addr 0x11, data 0x00400C82, status 0.
- DEPTH=2, req_ready_i=0, three WR updates -> two queued, third dropped; dtmcs dmistat=3; fourth update dropped even after the FIFO drains.
- Capture while a request is outstanding -> status 3, sticky; dmireset_i -> dmistat=0; a new update is accepted.
- rsp_err_i=1 on a read -> dmistat=2. A capture in the same cycle also sees pending -> dmistat stays 2 (failed wins).
- dtmhardreset_i in WAIT_RSP with 1 entry queued -> FIFO flushed, DRAIN; next rsp_valid_i discarded (last rdata unchanged); state IDLE; req_valid_o stays 0.
